mb_serial_decoder: RTL and testbench



---
 rtl/mb_serial_decoder.sv | 107 ++++++++++
 tb/tb_mb_serial_decoder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mb_serial_decoder.sv
// Serial radix-4 Booth digit decoder. It takes one {sign,one,two} digit per handshake, least-significant digit first,
// and rebuilds the exact two's-complement value of the frame.
module mb_serial_decoder #(
  parameter int DIGITS = 8,
  parameter int OUT_W  = 2*DIGITS+1,
  localparam int CNT_W = $clog2(DIGITS+1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign,
  input  logic                    in_one,
  input  logic                    in_two,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_value,
  output logic                    out_error,
  output logic [CNT_W-1:0]        digit_cnt
);

  // state   | meaning
  // COLLECT | accepting digits into the accumulator
  // HOLD    | frame complete, presenting value until out_ready
  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t                    state_q, state_d;
  logic signed [OUT_W-1:0]   acc_q, acc_d;
  logic                      err_q, err_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;

  logic signed [OUT_W-1:0]   mag_s;
  logic signed [OUT_W-1:0]   dig_s;
  logic signed [OUT_W-1:0]   term_s;
  logic [CNT_W:0]            shamt;
  logic                      illegal;
  logic                      last_digit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
      acc_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // The illegal code one=1,two=1 falls into the default case, so it adds nothing to the accumulator.
  always_comb begin
    mag_s = '0;
    case ({in_one, in_two})
      2'b10:   mag_s = {{(OUT_W-2){1'b0}}, 2'b01};
      2'b01:   mag_s = {{(OUT_W-2){1'b0}}, 2'b10};
      default: mag_s = '0;
    endcase
  end

  assign dig_s      = in_sign ? -mag_s : mag_s;
  assign shamt      = {cnt_q, 1'b0};
  assign term_s     = dig_s <<< shamt;
  assign illegal    = in_one & in_two;
  assign last_digit = (cnt_q == CNT_W'(DIGITS-1));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      COLLECT: begin
        if (in_valid) begin
          acc_d = acc_q + term_s;
          err_d = err_q | illegal;
          if (last_digit) begin
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          acc_d   = '0;
          err_d   = 1'b0;
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  assign in_ready  = (state_q == COLLECT);
  assign out_valid = (state_q == HOLD);
  assign out_value = acc_q;
  assign out_error = err_q;
  assign digit_cnt = cnt_q;

endmodule

// File: tb/tb_mb_serial_decoder.sv
// Directed bench for mb_serial_decoder: a table of whole frames, plus hand-written sequences for backpressure and mid-frame reset.
module tb_mb_serial_decoder;

  localparam int DIGITS = 8;
  localparam int OUT_W  = 2*DIGITS+1;
  localparam int CNT_W  = $clog2(DIGITS+1);

  // Digit codes, packed as {sign, one, two}
  localparam logic [2:0] Z   = 3'b000;
  localparam logic [2:0] NZ  = 3'b100;
  localparam logic [2:0] P1  = 3'b010;
  localparam logic [2:0] M1  = 3'b110;
  localparam logic [2:0] P2  = 3'b001;
  localparam logic [2:0] M2  = 3'b101;
  localparam logic [2:0] ILL = 3'b011;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_sign;
  logic                    in_one;
  logic                    in_two;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_value;
  logic                    out_error;
  logic [CNT_W-1:0]        digit_cnt;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  mb_serial_decoder #(.DIGITS(DIGITS), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_one    (in_one),
    .in_two    (in_two),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_value (out_value),
    .out_error (out_error),
    .digit_cnt (digit_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0][2:0]   digs;
    logic signed [16:0] val;
    logic               err;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
    assert_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send_digit(input logic [2:0] d);
    bit taken;
    taken = 1'b0;
    {in_sign, in_one, in_two} = d;
    in_valid = 1'b1;
    for (int k = 0; k < 20 && !taken; k++) begin
      taken = in_ready;
      @(posedge clk);
      @(negedge clk);
    end
    if (!taken) begin
      assert_cnt++;
      fail_cnt++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 20 cycles");
    end
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0][2:0] digs);
    for (int i = 0; i < DIGITS; i++) send_digit(digs[i]);
  endtask

  // Expects out_ready=1 and entry at the negedge right after the last accept.
  task automatic check_frame(input string tag, input logic signed [16:0] v, input logic e);
    check({tag, "_valid"}, OUT_W'(out_valid), OUT_W'(1));
    check({tag, "_value"}, out_value, v);
    check({tag, "_error"}, OUT_W'(out_error), OUT_W'(e));
    check({tag, "_ready_low"}, OUT_W'(in_ready), OUT_W'(0));
    @(posedge clk);
    @(negedge clk);
    check({tag, "_valid_drop"}, OUT_W'(out_valid), OUT_W'(0));
    check({tag, "_ready_back"}, OUT_W'(in_ready), OUT_W'(1));
  endtask

  initial begin
    tbl[0] = '{digs: {Z, Z, Z, Z, Z, Z, Z, P1},                val: 17'sd1,      err: 1'b0};
    tbl[1] = '{digs: {Z, P1, M1, M1, Z, P2, NZ, M2},           val: 17'sd2846,   err: 1'b0};
    tbl[2] = '{digs: {M2, M2, M2, M2, M2, M2, M2, M2},         val: -17'sd43690, err: 1'b0};
    tbl[3] = '{digs: {P2, P2, P2, P2, P2, P2, P2, P2},         val: 17'sd43690,  err: 1'b0};
    tbl[4] = '{digs: {P1, P1, P1, P1, ILL, P1, P1, P1},        val: 17'sd21781,  err: 1'b1};
    tbl[5] = '{digs: {Z, Z, Z, Z, Z, Z, Z, Z},                 val: 17'sd0,      err: 1'b0};
    tbl[6] = '{digs: {M1, M1, M1, M1, M1, M1, M1, M1},         val: -17'sd21845, err: 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_one    = 1'b0;
    in_two    = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    check("rst_in_ready",  OUT_W'(in_ready),  OUT_W'(1));
    check("rst_out_valid", OUT_W'(out_valid), OUT_W'(0));
    check("rst_out_value", out_value,         OUT_W'(0));
    check("rst_out_error", OUT_W'(out_error), OUT_W'(0));
    check("rst_digit_cnt", OUT_W'(digit_cnt), OUT_W'(0));

    for (int f = 0; f < 7; f++) begin
      send_frame(tbl[f].digs);
      check_frame($sformatf("frame%0d", f), tbl[f].val, tbl[f].err);
    end

    // Backpressure: the next frame's first digit is offered while the decoder sits in HOLD
    out_ready = 1'b0;
    send_frame(tbl[1].digs);
    {in_sign, in_one, in_two} = P1;
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("bp_ready_low%0d", c), OUT_W'(in_ready),  OUT_W'(0));
      check($sformatf("bp_valid%0d", c),     OUT_W'(out_valid), OUT_W'(1));
      check($sformatf("bp_value%0d", c),     out_value,         OUT_W'(17'sd2846));
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_consumed_valid", OUT_W'(out_valid), OUT_W'(0));
    check("bp_consumed_ready", OUT_W'(in_ready),  OUT_W'(1));
    check("bp_no_early_accept", OUT_W'(digit_cnt), OUT_W'(0));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_first_accept", OUT_W'(digit_cnt), OUT_W'(1));
    for (int i = 1; i < DIGITS; i++) send_digit(Z);
    check_frame("bp_next", 17'sd1, 1'b0);

    // Mid-frame reset discards the partial frame
    send_digit(P2);
    send_digit(P2);
    send_digit(P2);
    check("pre_rst_cnt", OUT_W'(digit_cnt), OUT_W'(3));
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_cnt",   OUT_W'(digit_cnt), OUT_W'(0));
    check("mid_rst_valid", OUT_W'(out_valid), OUT_W'(0));
    check("mid_rst_ready", OUT_W'(in_ready),  OUT_W'(1));
    check("mid_rst_value", out_value,         OUT_W'(0));
    send_frame(tbl[0].digs);
    check_frame("post_rst", 17'sd1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
